// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master arbiter and access sequencer for the shared memory/I-O bus.
// The monocycle CPU and a second master (DMA/loader, "ext") share one bus.
// Arbitration is round-robin. Every access holds the bus for WAIT_CYCLES
// cycles, and there is always one IDLE turnaround cycle between accesses.
//
// Parameters
//   ADDR_WIDTH   address width
//   DATA_WIDTH   data width
//   WAIT_CYCLES  bus cycles per access (must be >= 1)
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cpu_read/cpu_write    CPU request levels (write wins if both are high)
//   cpu_addr/cpu_wdata    CPU address and write data
//   cpu_rdata             read data to the CPU, valid in its last ACCESS cycle
//   cpu_stall             holds the CPU PC/state while its access is pending
//   ext_req/ext_we        ext request (held until ext_done) and direction
//   ext_addr/ext_wdata    ext address and write data
//   ext_gnt               ext owns the bus
//   ext_done              one-cycle pulse in the last ext ACCESS cycle
//   ext_rdata             registered ext read data
//   mem_addr/mem_wdata    latched bus address and write data
//   mem_rdata             bus read data
//   mem_read/mem_write    registered bus strobes, never both high
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_done,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_read,
  output logic                  mem_write
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic { IDLE, ACCESS } state_t;
  typedef enum logic { OWN_CPU, OWN_EXT } owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_owner;
  logic [CNT_W-1:0] cnt;

  logic cpu_rq;
  logic cpu_wins_write;
  logic last_cycle;
  logic ext_wins;

  assign cpu_rq         = cpu_read | cpu_write;
  assign cpu_wins_write = cpu_write;
  assign last_cycle     = (state == ACCESS) && (cnt == CNT_LAST);

  // Ext wins when it is the only requester, or on a tie when the CPU had
  // the previous grant (round-robin).
  assign ext_wins = ext_req && (!cpu_rq || (last_owner == OWN_CPU));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_EXT;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_rq || ext_req) begin
            state <= ACCESS;
            cnt   <= CNT_LOAD;
            if (ext_wins) begin
              owner      <= OWN_EXT;
              last_owner <= OWN_EXT;
              mem_addr   <= ext_addr;
              mem_wdata  <= ext_wdata;
              mem_read   <= ~ext_we;
              mem_write  <= ext_we;
            end else begin
              owner      <= OWN_CPU;
              last_owner <= OWN_CPU;
              mem_addr   <= cpu_addr;
              mem_wdata  <= cpu_wdata;
              mem_read   <= ~cpu_wins_write;
              mem_write  <= cpu_wins_write;
            end
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            // Always fall back to IDLE: the extra cycle is the bus turnaround.
            state     <= IDLE;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if ((owner == OWN_EXT) && mem_read) begin
              ext_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Release the CPU combinationally in its last ACCESS cycle so the
  // monocycle core completes the instruction on the same edge as the bus.
  assign cpu_stall = cpu_rq & ~(last_cycle & (owner == OWN_CPU));
  assign cpu_rdata = ((state == ACCESS) && (owner == OWN_CPU)) ? mem_rdata : '0;
  assign ext_gnt   = (state == ACCESS) && (owner == OWN_EXT);
  assign ext_done  = ext_gnt && (cnt == CNT_LAST);

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter (WAIT_CYCLES = 2): a directed vector
// table, hand-written corner sequences (ext request drop, reset mid-access)
// and a randomized run compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_read, cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_done;
  logic [DW-1:0] ext_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_read, mem_write;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_read (cpu_read),
    .cpu_write(cpu_write),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ext_req  (ext_req),
    .ext_we   (ext_we),
    .ext_addr (ext_addr),
    .ext_wdata(ext_wdata),
    .ext_gnt  (ext_gnt),
    .ext_done (ext_done),
    .ext_rdata(ext_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_read (mem_read),
    .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic xs, input logic [DW-1:0] xcrd,
                            input logic xmr, input logic xmw, input logic [AW-1:0] xma,
                            input logic [DW-1:0] xmwd, input logic xg, input logic xd,
                            input logic [DW-1:0] xerd);
    check({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(xs));
    check({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'(xcrd));
    check({tag, ".mem_read"},  32'(mem_read),  32'(xmr));
    check({tag, ".mem_write"}, 32'(mem_write), 32'(xmw));
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(xma));
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(xmwd));
    check({tag, ".ext_gnt"},   32'(ext_gnt),   32'(xg));
    check({tag, ".ext_done"},  32'(ext_done),  32'(xd));
    check({tag, ".ext_rdata"}, 32'(ext_rdata), 32'(xerd));
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cw, input logic er, input logic ew,
                        input logic [AW-1:0] ea, input logic [DW-1:0] edat,
                        input logic [DW-1:0] mrd);
    cpu_read  = rd;  cpu_write = wr;  cpu_addr  = ca;  cpu_wdata = cw;
    ext_req   = er;  ext_we    = ew;  ext_addr  = ea;  ext_wdata = edat;
    mem_rdata = mrd;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs {rd,wr,ext_req,ext_we} and expected flags
  // {cpu_stall,mem_read,mem_write,ext_gnt,ext_done}.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]    inf;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic [DW-1:0] mrd;
    logic [4:0]    xf;
    logic [DW-1:0] xcrd;
    logic [AW-1:0] xma;
    logic [DW-1:0] xmwd;
    logic [DW-1:0] xerd;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] inf, input logic [AW-1:0] caddr,
                              input logic [DW-1:0] cwd, input logic [AW-1:0] eaddr,
                              input logic [DW-1:0] ewd, input logic [DW-1:0] mrd,
                              input logic [4:0] xf, input logic [DW-1:0] xcrd,
                              input logic [AW-1:0] xma, input logic [DW-1:0] xmwd,
                              input logic [DW-1:0] xerd);
    vec_t v;
    v.inf = inf; v.caddr = caddr; v.cwd = cwd; v.eaddr = eaddr; v.ewd = ewd;
    v.mrd = mrd; v.xf = xf; v.xcrd = xcrd; v.xma = xma; v.xmwd = xmwd; v.xerd = xerd;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: one in-flight transaction record with a countdown of
  // remaining bus cycles (0 = bus free).
  // ---------------------------------------------------------------------------
  int            m_rem;
  bit            m_is_ext, m_rd, m_wr, m_last_ext;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_erd;

  task automatic model_reset();
    m_rem = 0; m_is_ext = 0; m_rd = 0; m_wr = 0; m_last_ext = 1;
    m_addr = '0; m_wdata = '0; m_erd = '0;
  endtask

  task automatic model_check(input string tag);
    bit busy, fin, rq;
    busy = (m_rem > 0);
    fin  = (m_rem == 1);
    rq   = cpu_read | cpu_write;
    check_outs(tag, rq && !(busy && !m_is_ext && fin),
               (busy && !m_is_ext) ? mem_rdata : '0,
               busy && m_rd, busy && m_wr, m_addr, m_wdata,
               busy && m_is_ext, busy && m_is_ext && fin, m_erd);
  endtask

  task automatic model_advance();
    bit rq, give_ext;
    rq = cpu_read | cpu_write;
    if (m_rem > 0) begin
      if (m_rem == 1 && m_is_ext && m_rd) m_erd = mem_rdata;
      m_rem--;
    end else if (rq || ext_req) begin
      give_ext   = ext_req && (!rq || !m_last_ext);
      m_is_ext   = give_ext;
      m_last_ext = give_ext;
      m_rem      = WC;
      if (give_ext) begin
        m_addr = ext_addr; m_wdata = ext_wdata; m_wr = ext_we;
      end else begin
        m_addr = cpu_addr; m_wdata = cpu_wdata; m_wr = cpu_write;
      end
      m_rd = !m_wr;
    end
  endtask

  vec_t vecs[$];

  initial begin
    // Stimulus table (WAIT_CYCLES = 2), applied right after reset.
    // CPU read alone
    vecs.push_back(mk(4'b1000, 20'h00123, 16'h0, 20'h0, 16'h0, 16'hBEEF, 5'b10000, 16'h0,    20'h00000, 16'h0, 16'h0));
    vecs.push_back(mk(4'b1000, 20'h00123, 16'h0, 20'h0, 16'h0, 16'hBEEF, 5'b11000, 16'hBEEF, 20'h00123, 16'h0, 16'h0));
    vecs.push_back(mk(4'b1000, 20'h00123, 16'h0, 20'h0, 16'h0, 16'hBEEF, 5'b01000, 16'hBEEF, 20'h00123, 16'h0, 16'h0));
    vecs.push_back(mk(4'b0000, 20'h00123, 16'h0, 20'h0, 16'h0, 16'hBEEF, 5'b00000, 16'h0,    20'h00123, 16'h0, 16'h0));
    // Ext write alone
    vecs.push_back(mk(4'b0011, 20'h0, 16'h0, 20'h00040, 16'h1234, 16'hBEEF, 5'b00000, 16'h0, 20'h00123, 16'h0,    16'h0));
    vecs.push_back(mk(4'b0011, 20'h0, 16'h0, 20'h00040, 16'h1234, 16'hBEEF, 5'b00110, 16'h0, 20'h00040, 16'h1234, 16'h0));
    vecs.push_back(mk(4'b0011, 20'h0, 16'h0, 20'h00040, 16'h1234, 16'hBEEF, 5'b00111, 16'h0, 20'h00040, 16'h1234, 16'h0));
    vecs.push_back(mk(4'b0000, 20'h0, 16'h0, 20'h00040, 16'h1234, 16'hBEEF, 5'b00000, 16'h0, 20'h00040, 16'h1234, 16'h0));
    // Simultaneous requests: CPU, EXT, CPU, EXT
    vecs.push_back(mk(4'b1010, 20'h00200, 16'h0, 20'h00300, 16'h0, 16'h5555, 5'b10000, 16'h0,    20'h00040, 16'h1234, 16'h0));
    vecs.push_back(mk(4'b1010, 20'h00200, 16'h0, 20'h00300, 16'h0, 16'h5555, 5'b11000, 16'h5555, 20'h00200, 16'h0,    16'h0));
    vecs.push_back(mk(4'b1010, 20'h00200, 16'h0, 20'h00300, 16'h0, 16'h5555, 5'b01000, 16'h5555, 20'h00200, 16'h0,    16'h0));
    vecs.push_back(mk(4'b1010, 20'h00201, 16'h0, 20'h00300, 16'h0, 16'h5555, 5'b10000, 16'h0,    20'h00200, 16'h0,    16'h0));
    vecs.push_back(mk(4'b1010, 20'h00201, 16'h0, 20'h00300, 16'h0, 16'h5555, 5'b11010, 16'h0,    20'h00300, 16'h0,    16'h0));
    vecs.push_back(mk(4'b1010, 20'h00201, 16'h0, 20'h00300, 16'h0, 16'h5555, 5'b11011, 16'h0,    20'h00300, 16'h0,    16'h0));
    vecs.push_back(mk(4'b1010, 20'h00201, 16'h0, 20'h00301, 16'h0, 16'h5555, 5'b10000, 16'h0,    20'h00300, 16'h0,    16'h5555));
    vecs.push_back(mk(4'b1010, 20'h00201, 16'h0, 20'h00301, 16'h0, 16'h5555, 5'b11000, 16'h5555, 20'h00201, 16'h0,    16'h5555));
    vecs.push_back(mk(4'b1010, 20'h00201, 16'h0, 20'h00301, 16'h0, 16'h5555, 5'b01000, 16'h5555, 20'h00201, 16'h0,    16'h5555));
    vecs.push_back(mk(4'b1010, 20'h00202, 16'h0, 20'h00301, 16'h0, 16'h5555, 5'b10000, 16'h0,    20'h00201, 16'h0,    16'h5555));
    vecs.push_back(mk(4'b1010, 20'h00202, 16'h0, 20'h00301, 16'h0, 16'h5555, 5'b11010, 16'h0,    20'h00301, 16'h0,    16'h5555));
    vecs.push_back(mk(4'b1010, 20'h00202, 16'h0, 20'h00301, 16'h0, 16'h5555, 5'b11011, 16'h0,    20'h00301, 16'h0,    16'h5555));
    vecs.push_back(mk(4'b0000, 20'h0,     16'h0, 20'h0,     16'h0, 16'h5555, 5'b00000, 16'h0,    20'h00301, 16'h0,    16'h5555));
    // CPU read+write together is a write
    vecs.push_back(mk(4'b1100, 20'h00077, 16'hABCD, 20'h0, 16'h0, 16'h5555, 5'b10000, 16'h0,    20'h00301, 16'h0,    16'h5555));
    vecs.push_back(mk(4'b1100, 20'h00077, 16'hABCD, 20'h0, 16'h0, 16'h5555, 5'b10100, 16'h5555, 20'h00077, 16'hABCD, 16'h5555));
    vecs.push_back(mk(4'b1100, 20'h00077, 16'hABCD, 20'h0, 16'h0, 16'h5555, 5'b00100, 16'h5555, 20'h00077, 16'hABCD, 16'h5555));
    vecs.push_back(mk(4'b0000, 20'h0,     16'h0,    20'h0, 16'h0, 16'h5555, 5'b00000, 16'h0,    20'h00077, 16'hABCD, 16'h5555));

    // Reset state
    reset = 1'b1;
    set_in(0, 0, '0, '0, 0, 0, '0, '0, '0);
    @(negedge clk);
    #1 check_outs("rst", 0, '0, 0, 0, '0, '0, 0, 0, '0);
    cpu_read = 1'b1;
    #1 check("rst.stall_follows_rq", 32'(cpu_stall), 32'd1);
    cpu_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 check_outs("post_rst0", 0, '0, 0, 0, '0, '0, 0, 0, '0);
    @(negedge clk);
    #1 check_outs("post_rst1", 0, '0, 0, 0, '0, '0, 0, 0, '0);

    // Directed table
    foreach (vecs[i]) begin
      @(negedge clk);
      set_in(vecs[i].inf[3], vecs[i].inf[2], vecs[i].caddr, vecs[i].cwd,
             vecs[i].inf[1], vecs[i].inf[0], vecs[i].eaddr, vecs[i].ewd, vecs[i].mrd);
      #1 check_outs($sformatf("vec%0d", i), vecs[i].xf[4], vecs[i].xcrd, vecs[i].xf[3],
                    vecs[i].xf[2], vecs[i].xma, vecs[i].xmwd, vecs[i].xf[1],
                    vecs[i].xf[0], vecs[i].xerd);
    end

    // Ext read with request dropped mid-access
    @(negedge clk);
    set_in(0, 0, '0, '0, 1, 0, 20'h00055, '0, 16'h0A5A);
    #1 check("drop.idle_gnt", 32'(ext_gnt), 32'd0);
    @(negedge clk);
    ext_req = 1'b0;
    #1 check("drop.gnt1", 32'(ext_gnt), 32'd1);
    check("drop.mem_read", 32'(mem_read), 32'd1);
    check("drop.mem_addr", 32'(mem_addr), 32'h00055);
    check("drop.done_early", 32'(ext_done), 32'd0);
    @(negedge clk);
    #1 check("drop.done", 32'(ext_done), 32'd1);
    check("drop.erd_before", 32'(ext_rdata), 32'h5555);
    @(negedge clk);
    mem_rdata = 16'hFFFF;
    #1 check("drop.erd_after", 32'(ext_rdata), 32'h0A5A);
    check("drop.gnt_off", 32'(ext_gnt), 32'd0);
    check("drop.mem_read_off", 32'(mem_read), 32'd0);
    @(negedge clk);
    set_in(0, 0, '0, '0, 1, 1, 20'h00066, 16'h7777, 16'hFFFF);
    @(negedge clk);
    #1 check("hold.mem_write", 32'(mem_write), 32'd1);
    @(negedge clk);
    #1 check("hold.done", 32'(ext_done), 32'd1);
    @(negedge clk);
    ext_req = 1'b0;
    #1 check("hold.erd", 32'(ext_rdata), 32'h0A5A);

    // Reset in the first ACCESS cycle of an ext write
    @(negedge clk);
    set_in(0, 0, '0, '0, 1, 1, 20'h00099, 16'h4321, 16'h0);
    @(negedge clk);
    #1 check("rma.mem_write", 32'(mem_write), 32'd1);
    check("rma.gnt", 32'(ext_gnt), 32'd1);
    #1 reset = 1'b1;
    #1 check("rma.mem_write_drop", 32'(mem_write), 32'd0);
    check("rma.gnt_drop", 32'(ext_gnt), 32'd0);
    check("rma.done", 32'(ext_done), 32'd0);
    check("rma.addr", 32'(mem_addr), 32'd0);
    set_in(1, 0, 20'h00088, '0, 1, 0, 20'h00011, '0, 16'h0);
    @(negedge clk);
    #1 check("rma.done_in_rst", 32'(ext_done), 32'd0);
    reset = 1'b0;
    #1 check("rma.idle_stall", 32'(cpu_stall), 32'd1);
    check("rma.idle_gnt", 32'(ext_gnt), 32'd0);
    @(negedge clk);
    #1 check("rma.cpu_wins_gnt", 32'(ext_gnt), 32'd0);
    check("rma.cpu_wins_read", 32'(mem_read), 32'd1);
    check("rma.cpu_wins_addr", 32'(mem_addr), 32'h00088);

    // Randomized run against the reference model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = (i == 0) || ($urandom_range(0, 149) == 0);
      cpu_read  = ($urandom_range(0, 2) != 0);
      cpu_write = ($urandom_range(0, 3) == 0);
      cpu_addr  = AW'($urandom);
      cpu_wdata = DW'($urandom);
      ext_req   = ($urandom_range(0, 1) != 0);
      ext_we    = ($urandom_range(0, 1) != 0);
      ext_addr  = AW'($urandom);
      ext_wdata = DW'($urandom);
      mem_rdata = DW'($urandom);
      if (reset) model_reset();
      #1 model_check($sformatf("rnd%0d", i));
      if (!reset) model_advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and access sequencer for the shared memory/I-O bus. Sits between the monocycle CPU bus port (`bus_addr`, `bus_data`, `read`, `write`) and the memory/I-O side, and lets a second master (DMA/loader, "ext") share the bus. The CPU is held through `cpu_stall`, which gates `enable_pc`. Arbitration is round-robin, and every access lasts a fixed, parameterised number of bus cycles.

## Interface
- `ADDR_WIDTH`, 20, address width
- `DATA_WIDTH`, 16, data width
- `WAIT_CYCLES`, 2, bus cycles per access in ACCESS state; legal range ≥1
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu_read`  in  1  CPU read request; level, held until the stall is released
- `cpu_write`  in  1  CPU write request; level, takes precedence over `cpu_read`
- `cpu_addr`  in  ADDR_WIDTH  CPU address
- `cpu_wdata`  in  DATA_WIDTH  CPU write data
- `cpu_rdata`  out  DATA_WIDTH  read data to CPU
- `cpu_stall`  out  1  hold CPU PC/state
- `ext_req`  in  1  ext request; held until `ext_done`
- `ext_we`  in  1  ext write (1) or read (0)
- `ext_addr`  in  ADDR_WIDTH  ext address
- `ext_wdata`  in  DATA_WIDTH  ext write data
- `ext_gnt`  out  1  ext owns the bus
- `ext_done`  out  1  ext access completes this cycle
- `ext_rdata`  out  DATA_WIDTH  registered ext read data
- `mem_addr`  out  ADDR_WIDTH  bus address
- `mem_wdata`  out  DATA_WIDTH  bus write data
- `mem_rdata`  in  DATA_WIDTH  bus read data
- `mem_read`  out  1  bus read strobe
- `mem_write`  out  1  bus write strobe

## Operation
- State machine with two states:
  - **IDLE:** no bus activity.
  - **ACCESS:** bus owned by `owner` (CPU or EXT).
- **IDLE arbitration.** Let `cpu_rq = cpu_read | cpu_write`.
  - If exactly one of `cpu_rq` and `ext_req` is high, that master wins.
  - If both are high, the master that is not `last_owner` wins.
- **On a win (registered at the clock edge):**
  - latch the winner's address, write data and direction;
  - set `owner` and `last_owner`;
  - load `cnt = WAIT_CYCLES`;
  - go to ACCESS.
- **ACCESS.**
  - `mem_addr` and `mem_wdata` drive the latched values.
  - `mem_read` = latched read; `mem_write` = latched write.
  - `cnt` decrements each cycle.
  - The last cycle is `cnt == 1`. On that edge the FSM always returns to IDLE; there are no back-to-back grants, which leaves one turnaround cycle.
- **`cpu_stall` (combinational).** `cpu_stall = cpu_rq & ~(state==ACCESS & owner==CPU & cnt==1)`.
- **`cpu_rdata` (combinational).** Equals `mem_rdata` while `owner==CPU` and `state==ACCESS`; 0 otherwise.
- **`ext_gnt`.** Equals `state==ACCESS & owner==EXT`.
- **`ext_done`.** Equals `ext_gnt & cnt==1` (combinational, one-cycle pulse).
- **`ext_rdata`.** Loaded from `mem_rdata` on the edge ending an ext read. Held until the next ext read completes.
- **Write precedence.** `cpu_read` and `cpu_write` both high is treated as a write; `mem_read` stays 0.
- **Dropped ext request.** If `ext_req` drops during ACCESS, the access still completes and `ext_done` still pulses. Latched values are never re-sampled mid-access.
- **Unchanging CPU request.** A CPU request that does not change after release is seen as a new request in the following IDLE. This matches monocycle behaviour, since the next instruction issues then.
- **Reset values.**
  - `state` = IDLE, `cnt` = 0, `last_owner` = EXT (so the CPU wins the first tie).
  - `mem_addr`, `mem_wdata`, `ext_rdata` = 0.
  - `mem_read`, `mem_write`, `ext_gnt`, `ext_done` = 0.
  - `cpu_stall` = `cpu_rq`; `cpu_rdata` = 0.
- **Reset mid-access.** The access is aborted immediately. Strobes drop asynchronously and no `ext_done` is generated.

## Timing
- Uncontended access occupies WAIT_CYCLES+1 cycles: 1 IDLE arbitration cycle plus WAIT_CYCLES ACCESS cycles.
- The CPU sees `cpu_stall` for exactly WAIT_CYCLES cycles per uncontended access, then one cycle with stall=0. That release cycle is the last ACCESS cycle, where `cpu_rdata` is valid.
- Worst-case CPU wait with ext contending: 2·(WAIT_CYCLES+1) − 1 stalled cycles.
- `mem_read`/`mem_write` are registered and glitch-free. They are never both high and are low in every IDLE cycle.
- `mem_rdata` is sampled in the last ACCESS cycle: combinationally for the CPU, at the clock edge for ext.
- `ext_req` must be low or new in the cycle after `ext_done`. If still high, it is treated as a new request.

## Test plan
All scenarios use WAIT_CYCLES=2.
- **Reset state:** assert `reset` with `cpu_read`=0 and `ext_req`=0 → all outputs 0 and state IDLE; after release, outputs stay 0.
- **CPU read alone:** `cpu_read`=1, `cpu_addr`=0x00123, `mem_rdata`=0xBEEF → `cpu_stall` is 1,1,0 over three cycles; `mem_read`=1 with `mem_addr`=0x00123 in cycles 2–3; `cpu_rdata`=0xBEEF in cycle 3; IDLE in cycle 4.
- **Ext write alone:** `ext_req`=1, `ext_we`=1, `ext_addr`=0x00040, `ext_wdata`=0x1234 → `ext_gnt`=1 for 2 cycles; `mem_write`=1 with 0x00040/0x1234; `ext_done` pulses in the second ACCESS cycle; `cpu_stall`=0 throughout.
- **Simultaneous requests after reset:** CPU is granted first. Ext is granted in the IDLE following CPU completion while the CPU keeps requesting, and the CPU stalls 5 cycles for its next access. Grants alternate CPU, EXT, CPU, EXT over 4 accesses.
- **Ext read, then request drop:** ext reads 0x0A5A, then drops `ext_req` mid-access → `ext_done` still pulses; `ext_rdata`=0x0A5A from the next cycle and holds until the next ext read.
- **Reset mid-access:** assert `reset` in the first ACCESS cycle of an ext write → `mem_write` and `ext_gnt` drop immediately with no `ext_done`; after release, the CPU wins the first tie.
